// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, state encoding and alignment rule for the data-memory arbiter
package dmem_pkg;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Rejected accesses: reserved mode, or an address not aligned to the access size.
    function automatic logic is_bad(input logic [1:0] lsb, input logic [1:0] mode);
        is_bad = (mode == MODE_RSVD)
               | ((mode == MODE_HALF) & lsb[0])
               | ((mode == MODE_WORD) & (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_subword_extract.sv
// rtl/dmem_subword_extract.sv - picks a zero-extended byte/halfword/word lane out of a memory word
module dmem_subword_extract
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lsb,
    input  logic [1:0]  mode,
    output logic [31:0] data,
    output logic        bad
);

    always_comb begin
        bad  = is_bad(lsb, mode);
        data = '0;
        case (mode)
            MODE_BYTE: begin
                case (lsb)
                    2'd0:    data[7:0] = word[7:0];
                    2'd1:    data[7:0] = word[15:8];
                    2'd2:    data[7:0] = word[23:16];
                    default: data[7:0] = word[31:24];
                endcase
            end
            MODE_HALF: data[15:0] = lsb[1] ? word[31:16] : word[15:0];
            MODE_WORD: data = word;
            default:   data = '0;
        endcase
        if (bad) begin
            data = '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of one data-memory port between CPU and debug loader
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [31:0]           wdata0,
    input  logic [31:0]           wdata1,
    input  logic [1:0]            mode0,
    input  logic [1:0]            mode1,
    input  logic                  wr0,
    input  logic                  wr1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err0,
    output logic                  err1,
    output logic [31:0]           rdata0,
    output logic [31:0]           rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [1:0]            mem_mode,
    output logic                  mem_str,
    output logic                  mem_sel,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    win_q, win_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic [1:0]              mem_mode_q, mem_mode_d;
    logic                    mem_sel_q, mem_sel_d;
    logic                    mem_str_q, mem_str_d;
    logic                    ack0_q, ack0_d, ack1_q, ack1_d;
    logic                    err0_q, err0_d, err1_q, err1_d;
    logic [31:0]             rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic                    sel_port;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_wdata;
    logic [1:0]              sel_mode;
    logic                    sel_wr;
    logic [31:0]             ext_data;
    logic                    ext_bad;

    dmem_subword_extract u_extract (
        .word (mem_rdata),
        .lsb  (mem_addr_q[1:0]),
        .mode (mem_mode_q),
        .data (ext_data),
        .bad  (ext_bad)
    );

    always_comb begin
        // With both requesting, the port that did not win last time goes next.
        sel_port  = (req0 & req1) ? ~last_q : req1;
        sel_addr  = sel_port ? addr1  : addr0;
        sel_wdata = sel_port ? wdata1 : wdata0;
        sel_mode  = sel_port ? mode1  : mode0;
        sel_wr    = sel_port ? wr1    : wr0;

        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_mode_d  = mem_mode_q;
        mem_sel_d   = 1'b0;
        mem_str_d   = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    win_d       = sel_port;
                    last_d      = sel_port;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_mode_d  = sel_mode;
                    mem_sel_d   = 1'b1;
                    mem_str_d   = sel_wr & ~is_bad(sel_addr[1:0], sel_mode);
                    state_d     = ST_ACC;
                end
            end
            ST_ACC: begin
                if (win_q == PORT_DBG) begin
                    ack1_d   = 1'b1;
                    err1_d   = ext_bad;
                    rdata1_d = ext_data;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = ext_bad;
                    rdata0_d = ext_data;
                end
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            win_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mode_q  <= '0;
            mem_sel_q   <= 1'b0;
            mem_str_q   <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_mode_q  <= mem_mode_d;
            mem_sel_q   <= mem_sel_d;
            mem_str_q   <= mem_str_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_mode  = mem_mode_q;
    assign mem_sel   = mem_sel_q;
    assign mem_str   = mem_str_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
